game_ctrl_fsm: RTL
==================

Name: game_ctrl_fsm

Overview:
- Game-level sequencer for the dragon/robot playfield.
- Consumes the collision Event bus and the 1 Hz tick.
- Owns score, lives, level and round timer.
- Issues move_en to freeze the dragon and robot movers during hit-recovery, level-up and game-over phases.
- Drives status values consumed by mem_gen and the score display.

Parameters:
- LIVES_INIT, 3, lives loaded on game start (1..3).
- LEVEL_STEP, 5, score hits per level increment.
- MAX_LEVEL, 7, level saturation value.
- ROUND_TIME, 60, seconds per round (1..127).
- HIT_HOLD, 24, clk_22 cycles frozen after the robot is hurt (~1 s).
- LVL_HOLD, 48, clk_22 cycles frozen on level-up.
- SCORE_MAX, 9999, score saturation value.

Ports:
- clk_22  in  1  system game clock (100 MHz / 2^22).
- rst  in  1  asynchronous, active-low reset.
- start  in  1  debounced start button, level.
- clk_1Hz  in  1  1 Hz clock, sampled as data in the clk_22 domain.
- Event  in  2  [1] = robot scored on dragon, [0] = robot hurt; level signals.
- state  out  3  current FSM state encoding.
- move_en  out  1  movers may advance.
- score  out  14  current score.
- lives  out  2  remaining lives.
- level  out  3  current level (1..MAX_LEVEL).
- time_left  out  7  seconds remaining in the round.
- flash  out  1  robot blink enable for mem_gen.
- game_over  out  1  high in OVER.

Behaviour:
- Reset: rst is asynchronous, active-low; clock is clk_22. On reset:
  - state=IDLE, move_en=0, score=0, lives=LIVES_INIT, level=1, time_left=ROUND_TIME, flash=0, game_over=0.
  - hold_cnt=0, step_cnt=0.
  - Edge registers for Event and clk_1Hz reset to 0; the start edge register resets to 1, so a button held through reset does not start a game.
- Edge detection: all inputs are sampled in clk_22. Only rising edges (prev=0, cur=1) act, so a level held for several cycles counts once. Edges produce registered effects on the next clk_22 edge (1-cycle latency).
- State encodings: IDLE=0, PLAY=1, HIT=2, LVLUP=3, OVER=4. Codes 5–7 are illegal and go to IDLE.
- IDLE (move_en=0):
  - start edge -> PLAY.
  - Same edge loads score=0, lives=LIVES_INIT, level=1, time_left=ROUND_TIME, step_cnt=0.
- PLAY (move_en=1). Evaluated each cycle:
  - Event[1] edge:
    - score+1, saturating at SCORE_MAX.
    - step_cnt+1; at LEVEL_STEP, step_cnt wraps to 0.
    - If level<MAX_LEVEL: level+1, hold_cnt=LVL_HOLD-1, time_left=ROUND_TIME, next=LVLUP.
    - If level==MAX_LEVEL: no level change, stay in PLAY.
  - Event[0] edge:
    - lives-1.
    - If lives was 1 -> OVER (lives=0).
    - Otherwise hold_cnt=HIT_HOLD-1 -> HIT.
  - Both Event edges in the same cycle: both score and lives update, and any level increment still applies. Next-state priority is OVER > HIT > LVLUP.
  - 1 Hz edge: time_left-1. At time_left==1 the decrement gives 0 and the next state is OVER, unless a higher-priority transition fires in the same cycle.
  - start edge: ignored.
- HIT (move_en=0):
  - flash = hold_cnt[2].
  - Event edges, 1 Hz edges and start are ignored; the timer is frozen.
  - hold_cnt decrements each cycle; at 0 -> PLAY, flash=0.
- LVLUP (move_en=0):
  - flash=0.
  - All edges ignored; hold_cnt decrements; at 0 -> PLAY.
- OVER (move_en=0, game_over=1):
  - Score and level hold for display.
  - start edge -> PLAY with the same loads as IDLE.
- Reset mid-operation: immediate return to reset values regardless of state and hold_cnt.

Decomposition:
- Package game_pkg holds:
  - state localparams IDLE/PLAY/HIT/LVLUP/OVER and the state width (3).
  - Event bit indices EV_SCORE=1, EV_HURT=0.
  - Widths for score (14), lives (2), level (3) and time (7).
- One sub-module, edge_rise:
  - Parameter RST_VAL; ports clk, rst, d, pulse.
  - Instantiated for start, clk_1Hz, Event[1] and Event[0].

Test Plan:
- Hold start=1 through reset release -> stays IDLE. Drop start then raise it -> PLAY one cycle later; move_en=1, lives=3, level=1, time_left=60, score=0.
- In PLAY, hold Event[1] high for 5 cycles -> score=1 (single count). Pulse Event[1] 4 more times -> score=5, level=2, state=LVLUP, move_en=0 for 48 cycles, time_left=60, then PLAY.
- Event[0] pulse with lives=3 -> lives=2, HIT for 24 cycles with flash toggling every 4 cycles, an Event[1] pulse during HIT leaves score unchanged, then PLAY. A third hurt at lives=1 -> OVER, game_over=1, lives=0.
- Event[0] and Event[1] rise in the same cycle at score=4, lives=2 -> score=5, level=2, lives=1, state=HIT (not LVLUP).
- Apply 60 clk_1Hz edges in PLAY -> time_left counts 60..0, state=OVER on the 60th. A start edge then gives PLAY with score=0, lives=3, time_left=60.
- Assert rst low while in HIT with hold_cnt=10 -> state=IDLE, move_en=0, flash=0, score=0 immediately (asynchronous).

Source files
------------

// File: rtl/game_pkg.sv
// rtl/game_pkg.sv - shared state codes, event bit indices and field widths for the game sequencer
package game_pkg;

    localparam int STATE_W  = 3;
    localparam int EV_SCORE = 1;
    localparam int EV_HURT  = 0;
    localparam int SCORE_W  = 14;
    localparam int LIVES_W  = 2;
    localparam int LEVEL_W  = 3;
    localparam int TIME_W   = 7;

    typedef enum logic [STATE_W-1:0] {
        IDLE  = 3'd0,
        PLAY  = 3'd1,
        HIT   = 3'd2,
        LVLUP = 3'd3,
        OVER  = 3'd4
    } state_t;

endpackage

// File: rtl/edge_rise.sv
// rtl/edge_rise.sv - rising-edge detector; previous-sample register resets to RST_VAL
module edge_rise #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic pulse
);

    logic prev_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            prev_q <= RST_VAL;
        end else begin
            prev_q <= d;
        end
    end

    assign pulse = d & ~prev_q;

endmodule

// File: rtl/game_ctrl_fsm.sv
// rtl/game_ctrl_fsm.sv - game-level sequencer: score, lives, level, round timer and mover freeze
module game_ctrl_fsm
    import game_pkg::*;
#(
    parameter int LIVES_INIT = 3,
    parameter int LEVEL_STEP = 5,
    parameter int MAX_LEVEL  = 7,
    parameter int ROUND_TIME = 60,
    parameter int HIT_HOLD   = 24,
    parameter int LVL_HOLD   = 48,
    parameter int SCORE_MAX  = 9999
) (
    input  logic               clk_22,
    input  logic               rst,
    input  logic               start,
    input  logic               clk_1Hz,
    input  logic [1:0]         Event,
    output logic [STATE_W-1:0] state,
    output logic               move_en,
    output logic [SCORE_W-1:0] score,
    output logic [LIVES_W-1:0] lives,
    output logic [LEVEL_W-1:0] level,
    output logic [TIME_W-1:0]  time_left,
    output logic               flash,
    output logic               game_over
);

    localparam int HOLD_W = $clog2(((LVL_HOLD > HIT_HOLD) ? LVL_HOLD : HIT_HOLD) + 1);
    localparam int STEP_W = $clog2(LEVEL_STEP + 1);

    localparam logic [SCORE_W-1:0] SCORE_SAT = SCORE_W'(SCORE_MAX);
    localparam logic [LIVES_W-1:0] LIVES_LD  = LIVES_W'(LIVES_INIT);
    localparam logic [LEVEL_W-1:0] LEVEL_TOP = LEVEL_W'(MAX_LEVEL);
    localparam logic [TIME_W-1:0]  TIME_LD   = TIME_W'(ROUND_TIME);
    localparam logic [HOLD_W-1:0]  HIT_LD    = HOLD_W'(HIT_HOLD - 1);
    localparam logic [HOLD_W-1:0]  LVL_LD    = HOLD_W'(LVL_HOLD - 1);
    localparam logic [STEP_W-1:0]  STEP_LAST = STEP_W'(LEVEL_STEP - 1);

    logic start_p, tick_p, score_p, hurt_p;

    // A start button held through reset must not look like a fresh press
    edge_rise #(.RST_VAL(1'b1)) u_start_edge (.clk(clk_22), .rst(rst), .d(start),           .pulse(start_p));
    edge_rise #(.RST_VAL(1'b0)) u_tick_edge  (.clk(clk_22), .rst(rst), .d(clk_1Hz),         .pulse(tick_p));
    edge_rise #(.RST_VAL(1'b0)) u_score_edge (.clk(clk_22), .rst(rst), .d(Event[EV_SCORE]), .pulse(score_p));
    edge_rise #(.RST_VAL(1'b0)) u_hurt_edge  (.clk(clk_22), .rst(rst), .d(Event[EV_HURT]),  .pulse(hurt_p));

    state_t             state_q, state_d;
    logic               move_en_q, move_en_d;
    logic [SCORE_W-1:0] score_q, score_d;
    logic [LIVES_W-1:0] lives_q, lives_d;
    logic [LEVEL_W-1:0] level_q, level_d;
    logic [TIME_W-1:0]  time_q, time_d;
    logic               flash_q, flash_d;
    logic               game_over_q, game_over_d;
    logic [HOLD_W-1:0]  hold_q, hold_d;
    logic [STEP_W-1:0]  step_q, step_d;

    always_comb begin
        state_d = state_q;
        score_d = score_q;
        lives_d = lives_q;
        level_d = level_q;
        time_d  = time_q;
        hold_d  = hold_q;
        step_d  = step_q;

        case (state_q)
            IDLE, OVER: begin
                if (start_p) begin
                    state_d = PLAY;
                    score_d = '0;
                    lives_d = LIVES_LD;
                    level_d = LEVEL_W'(1);
                    time_d  = TIME_LD;
                    step_d  = '0;
                end
            end
            PLAY: begin
                // Later assignments win: timeout < level-up < hurt < last life lost
                if (time_q == '0) begin
                    state_d = OVER;
                end
                if (tick_p && time_q != '0) begin
                    time_d = time_q - TIME_W'(1);
                    if (time_q == TIME_W'(1)) begin
                        state_d = OVER;
                    end
                end
                if (score_p) begin
                    if (score_q != SCORE_SAT) begin
                        score_d = score_q + SCORE_W'(1);
                    end
                    if (step_q == STEP_LAST) begin
                        step_d = '0;
                        if (level_q < LEVEL_TOP) begin
                            level_d = level_q + LEVEL_W'(1);
                            hold_d  = LVL_LD;
                            time_d  = TIME_LD;
                            state_d = LVLUP;
                        end
                    end else begin
                        step_d = step_q + STEP_W'(1);
                    end
                end
                if (hurt_p) begin
                    lives_d = lives_q - LIVES_W'(1);
                    if (lives_q == LIVES_W'(1)) begin
                        state_d = OVER;
                    end else begin
                        hold_d  = HIT_LD;
                        state_d = HIT;
                    end
                end
            end
            HIT, LVLUP: begin
                if (hold_q == '0) begin
                    state_d = PLAY;
                end else begin
                    hold_d = hold_q - HOLD_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase

        move_en_d   = (state_d == PLAY);
        game_over_d = (state_d == OVER);
        flash_d     = (state_d == HIT) && hold_d[2];
    end

    always_ff @(posedge clk_22 or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            move_en_q   <= 1'b0;
            score_q     <= '0;
            lives_q     <= LIVES_LD;
            level_q     <= LEVEL_W'(1);
            time_q      <= TIME_LD;
            flash_q     <= 1'b0;
            game_over_q <= 1'b0;
            hold_q      <= '0;
            step_q      <= '0;
        end else begin
            state_q     <= state_d;
            move_en_q   <= move_en_d;
            score_q     <= score_d;
            lives_q     <= lives_d;
            level_q     <= level_d;
            time_q      <= time_d;
            flash_q     <= flash_d;
            game_over_q <= game_over_d;
            hold_q      <= hold_d;
            step_q      <= step_d;
        end
    end

    assign state     = state_q;
    assign move_en   = move_en_q;
    assign score     = score_q;
    assign lives     = lives_q;
    assign level     = level_q;
    assign time_left = time_q;
    assign flash     = flash_q;
    assign game_over = game_over_q;

endmodule
